// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged core/peripheral/application reset release after PLL lock
module reset_sequencer #(
  parameter int LOCK_FILT  = 16,
  parameter int STAGE_DLY  = 32,
  parameter int SW_RST_LEN = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  input  logic             lock_lost_clr,
  output logic             rst_core,
  output logic             rst_periph,
  output logic             rst_app,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] rst_count
);

  localparam int LW   = $clog2(LOCK_FILT + 1);
  localparam int DMAX = (STAGE_DLY > SW_RST_LEN) ? STAGE_DLY : SW_RST_LEN;
  localparam int DW   = $clog2(DMAX + 1);

  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILT - 1);
  localparam logic [DW-1:0] STAGE_LAST = DW'(STAGE_DLY - 1);
  localparam logic [DW-1:0] SW_LAST    = DW'(SW_RST_LEN - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    REL_CORE,
    REL_PERIPH,
    RUN,
    SW_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [DW-1:0]    dly_cnt_q, dly_cnt_d;
  logic             rst_core_q, rst_core_d;
  logic             rst_periph_q, rst_periph_d;
  logic             rst_app_q, rst_app_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] rst_count_q, rst_count_d;
  logic [CNT_W-1:0] count_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      lock_cnt_q   <= '0;
      dly_cnt_q    <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      rst_app_q    <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      rst_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      rst_app_q    <= rst_app_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      rst_count_q  <= rst_count_d;
    end
  end

  assign count_inc = (&rst_count_q) ? rst_count_q : rst_count_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    dly_cnt_d    = dly_cnt_q;
    rst_core_d   = rst_core_q;
    rst_periph_d = rst_periph_q;
    rst_app_d    = rst_app_q;
    ready_d      = ready_q;
    // A lock-loss set below overrides a same-edge clear.
    lock_lost_d  = lock_lost_q & ~lock_lost_clr;
    rst_count_d  = rst_count_q;

    case (state_q)
      WAIT_LOCK: begin
        rst_core_d   = 1'b1;
        rst_periph_d = 1'b1;
        rst_app_d    = 1'b1;
        ready_d      = 1'b0;
        if (!pll_locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d = '0;
          rst_core_d = 1'b0;
          dly_cnt_d  = '0;
          state_d    = REL_CORE;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end

      REL_CORE, REL_PERIPH, RUN: begin
        if (!pll_locked || sw_rst_req) begin
          rst_core_d   = 1'b1;
          rst_periph_d = 1'b1;
          rst_app_d    = 1'b1;
          ready_d      = 1'b0;
          rst_count_d  = count_inc;
          if (!pll_locked) begin
            lock_lost_d = 1'b1;
            lock_cnt_d  = '0;
            state_d     = WAIT_LOCK;
          end else begin
            dly_cnt_d = '0;
            state_d   = SW_HOLD;
          end
        end else if (state_q == REL_CORE) begin
          if (dly_cnt_q == STAGE_LAST) begin
            rst_periph_d = 1'b0;
            dly_cnt_d    = '0;
            state_d      = REL_PERIPH;
          end else begin
            dly_cnt_d = dly_cnt_q + DW'(1);
          end
        end else if (state_q == REL_PERIPH) begin
          if (dly_cnt_q == STAGE_LAST) begin
            rst_app_d = 1'b0;
            ready_d   = 1'b1;
            dly_cnt_d = '0;
            state_d   = RUN;
          end else begin
            dly_cnt_d = dly_cnt_q + DW'(1);
          end
        end
      end

      SW_HOLD: begin
        rst_core_d   = 1'b1;
        rst_periph_d = 1'b1;
        rst_app_d    = 1'b1;
        ready_d      = 1'b0;
        if (!pll_locked) begin
          lock_lost_d = 1'b1;
          lock_cnt_d  = '0;
          state_d     = WAIT_LOCK;
        end else if (dly_cnt_q == SW_LAST) begin
          lock_cnt_d = '0;
          state_d    = WAIT_LOCK;
        end else begin
          dly_cnt_d = dly_cnt_q + DW'(1);
        end
      end

      default: begin
        rst_core_d   = 1'b1;
        rst_periph_d = 1'b1;
        rst_app_d    = 1'b1;
        ready_d      = 1'b0;
        lock_cnt_d   = '0;
        state_d      = WAIT_LOCK;
      end
    endcase
  end

  assign rst_core   = rst_core_q;
  assign rst_periph = rst_periph_q;
  assign rst_app    = rst_app_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign rst_count  = rst_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic       rst_core, rst_periph, rst_app, ready, lock_lost;
  logic [7:0] rst_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  reset_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .lock_lost_clr (lock_lost_clr),
    .rst_core      (rst_core),
    .rst_periph    (rst_periph),
    .rst_app       (rst_app),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .rst_count     (rst_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       sel = rst_core;
      1:       sel = rst_periph;
      2:       sel = rst_app;
      default: sel = ~ready;
    endcase
  endfunction

  // Edges until the selected active-high signal reads 0; -1 on timeout.
  task automatic cycles_until(input int w, input int limit, output int n);
    n = 0;
    while (sel(w) !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    if (sel(w) !== 1'b0) n = -1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (5) step();
    total_cnt++;
    if ({rst_core, rst_periph, rst_app, ready, lock_lost} !== 5'b11100 || rst_count !== 8'd0)
      $display("FAIL reset_state: got %b cnt %0d expected 11100 cnt 0",
               {rst_core, rst_periph, rst_app, ready, lock_lost}, rst_count);
    else pass_cnt++;
    rst = 1'b0;
    cycles_until(0, 100, n);
    total_cnt++;
    if (n !== 16) $display("FAIL seq_core_delay: got %0d expected 16", n);
    else pass_cnt++;
    total_cnt++;
    if ({rst_periph, rst_app, ready} !== 3'b110)
      $display("FAIL seq_order_core: got %b expected 110", {rst_periph, rst_app, ready});
    else pass_cnt++;
    cycles_until(1, 100, n);
    total_cnt++;
    if (n !== 32) $display("FAIL seq_periph_delay: got %0d expected 32", n);
    else pass_cnt++;
    total_cnt++;
    if ({rst_app, ready} !== 2'b10)
      $display("FAIL seq_order_periph: got %b expected 10", {rst_app, ready});
    else pass_cnt++;
    cycles_until(2, 100, n);
    total_cnt++;
    if (n !== 32) $display("FAIL seq_app_delay: got %0d expected 32", n);
    else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1 || rst_count !== 8'd0 || lock_lost !== 1'b0)
      $display("FAIL seq_run_state: got ready %b cnt %0d lost %b expected 1 0 0",
               ready, rst_count, lock_lost);
    else pass_cnt++;
  endtask

  task automatic test_filter_restart();
    int n;
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    pll_locked = 1'b1;
    repeat (10) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    cycles_until(0, 100, n);
    total_cnt++;
    if (n !== 16) $display("FAIL filter_restart: got %0d expected 16", n);
    else pass_cnt++;
    total_cnt++;
    if (lock_lost !== 1'b0 || rst_count !== 8'd0)
      $display("FAIL filter_no_event: got lost %b cnt %0d expected 0 0", lock_lost, rst_count);
    else pass_cnt++;
    cycles_until(3, 200, n);
    total_cnt++;
    if (n !== 64) $display("FAIL filter_to_run: got %0d expected 64", n);
    else pass_cnt++;
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    total_cnt++;
    if ({rst_core, rst_periph, rst_app, ready, lock_lost} !== 5'b11101 || rst_count !== 8'd1)
      $display("FAIL lockloss_state: got %b cnt %0d expected 11101 cnt 1",
               {rst_core, rst_periph, rst_app, ready, lock_lost}, rst_count);
    else pass_cnt++;
    cycles_until(0, 100, n);
    total_cnt++;
    if (n !== 16) $display("FAIL lockloss_core_delay: got %0d expected 16", n);
    else pass_cnt++;
    cycles_until(3, 200, n);
    total_cnt++;
    if (n !== 64) $display("FAIL lockloss_to_run: got %0d expected 64", n);
    else pass_cnt++;
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    total_cnt++;
    if (lock_lost !== 1'b0 || rst_count !== 8'd1)
      $display("FAIL lockloss_clear: got lost %b cnt %0d expected 0 1", lock_lost, rst_count);
    else pass_cnt++;
  endtask

  task automatic test_sw_reset();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cycles_until(3, 200, n);
    total_cnt++;
    if (n !== 80) $display("FAIL sw_bringup: got %0d expected 80", n);
    else pass_cnt++;
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    total_cnt++;
    if ({rst_core, rst_periph, rst_app, ready} !== 4'b1110 || rst_count !== 8'd1)
      $display("FAIL sw_assert: got %b cnt %0d expected 1110 cnt 1",
               {rst_core, rst_periph, rst_app, ready}, rst_count);
    else pass_cnt++;
    repeat (63) step();
    total_cnt++;
    if ({rst_core, rst_periph, rst_app} !== 3'b111)
      $display("FAIL sw_hold: got %b expected 111", {rst_core, rst_periph, rst_app});
    else pass_cnt++;
    cycles_until(0, 100, n);
    total_cnt++;
    if (n !== 17) $display("FAIL sw_release: got %0d expected 17", n);
    else pass_cnt++;
    total_cnt++;
    if (rst_count !== 8'd1 || lock_lost !== 1'b0)
      $display("FAIL sw_flags: got cnt %0d lost %b expected 1 0", rst_count, lock_lost);
    else pass_cnt++;
  endtask

  task automatic test_sw_hold_lock_loss();
    int n;
    cycles_until(3, 200, n);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    total_cnt++;
    if (lock_lost !== 1'b1 || rst_count !== 8'd2 || rst_core !== 1'b1)
      $display("FAIL swhold_lockloss: got lost %b cnt %0d core %b expected 1 2 1",
               lock_lost, rst_count, rst_core);
    else pass_cnt++;
    cycles_until(0, 200, n);
    total_cnt++;
    if (n !== 16) $display("FAIL swhold_lockloss_release: got %0d expected 16", n);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_periph();
    int n;
    cycles_until(1, 100, n);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({rst_core, rst_periph, rst_app, ready, lock_lost} !== 5'b11100 || rst_count !== 8'd0)
      $display("FAIL midrst_state: got %b cnt %0d expected 11100 cnt 0",
               {rst_core, rst_periph, rst_app, ready, lock_lost}, rst_count);
    else pass_cnt++;
    cycles_until(0, 100, n);
    total_cnt++;
    if (n !== 16) $display("FAIL midrst_restart: got %0d expected 16", n);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int n;
    int bad;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cycles_until(0, 100, n);
    pll_locked = 1'b0;
    sw_rst_req = 1'b1;
    step();
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    total_cnt++;
    if (rst_count !== 8'd1 || lock_lost !== 1'b1 || rst_core !== 1'b1)
      $display("FAIL same_edge_event: got cnt %0d lost %b core %b expected 1 1 1",
               rst_count, lock_lost, rst_core);
    else pass_cnt++;
    cycles_until(0, 200, n);
    total_cnt++;
    if (n !== 16) $display("FAIL same_edge_path: got %0d expected 16", n);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      cycles_until(0, 40, n);
      if (n != 16) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL sat_loop_timing: got %0d bad iterations expected 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (rst_count !== 8'd255) $display("FAIL sat_count: got %0d expected 255", rst_count);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_filter_restart();
    test_lock_loss();
    test_sw_reset();
    test_sw_hold_lock_loss();
    test_rst_mid_periph();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the power-on reset and drives staged reset release for the FEC subsystems. The power-on reset is inverted to the active-high `rst` input. The block waits for a stable PLL/MMCM lock, then releases three reset domains in order: core, then peripheral, then application. Lock loss or a software reset request re-runs the sequence. It sits between the power-on reset stage and the rest of the design's reset tree.

Parameters:
LOCK_FILT, 16, consecutive cycles `pll_locked` must be high before release begins (>=2)
STAGE_DLY, 32, cycles between successive domain releases (>=2)
SW_RST_LEN, 64, cycles all domains are held in reset after a software request (>=2)
CNT_W, 8, width of `rst_count`

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset (power-on reset, inverted)
pll_locked  input  1  PLL lock status, async to nothing (same clk domain, pre-synchronised)
sw_rst_req  input  1  single-cycle software reset request
lock_lost_clr  input  1  clears `lock_lost` sticky flag
rst_core  output  1  active-high reset, core domain
rst_periph  output  1  active-high reset, peripheral domain
rst_app  output  1  active-high reset, application domain
ready  output  1  high when all domains released (state RUN)
lock_lost  output  1  sticky: lock dropped after release began
rst_count  output  CNT_W  saturating count of re-sequence events (lock loss + sw requests)

Behaviour:
- All outputs are registered.
- While `rst`=1 (synchronous, highest priority):
  - state <= WAIT_LOCK.
  - `rst_core` = `rst_periph` = `rst_app` = 1; `ready` = 0; `lock_lost` = 0; `rst_count` = 0.
  - `lock_cnt` and `dly_cnt` are cleared.
- States: WAIT_LOCK, REL_CORE, REL_PERIPH, RUN, SW_HOLD.
- WAIT_LOCK:
  - All resets asserted.
  - `lock_cnt` increments each cycle `pll_locked`=1 and clears to 0 when `pll_locked`=0.
  - On the edge where `pll_locked`=1 and `lock_cnt`==LOCK_FILT-1: `rst_core` <= 0, `dly_cnt` <= 0, go to REL_CORE.
  - `rst_core` therefore falls exactly LOCK_FILT sampled-high cycles after lock rises.
- REL_CORE:
  - `dly_cnt` increments each cycle.
  - When `dly_cnt`==STAGE_DLY-1: `rst_periph` <= 0, `dly_cnt` <= 0, go to REL_PERIPH.
- REL_PERIPH:
  - Same counting as REL_CORE.
  - When `dly_cnt`==STAGE_DLY-1: `rst_app` <= 0, `ready` <= 1, go to RUN.
- Deassertion spacing: exactly STAGE_DLY cycles between falling edges of `rst_core`→`rst_periph` and `rst_periph`→`rst_app`.
- RUN: holds until an event below occurs.
- Lock loss: `pll_locked`=0 sampled in REL_CORE, REL_PERIPH or RUN.
  - Next edge: all three resets <= 1, `ready` <= 0, `lock_lost` <= 1, `rst_count` += 1, `lock_cnt` <= 0.
  - Go to WAIT_LOCK.
- Software reset: `sw_rst_req`=1 in REL_CORE, REL_PERIPH or RUN with `pll_locked`=1.
  - Next edge: all resets <= 1, `ready` <= 0, `rst_count` += 1, `dly_cnt` <= 0, go to SW_HOLD.
- SW_HOLD:
  - Resets held for SW_RST_LEN cycles (`dly_cnt`==SW_RST_LEN-1), then go to WAIT_LOCK with `lock_cnt` <= 0, so the full lock filter re-runs.
  - Lock loss during SW_HOLD: go straight to WAIT_LOCK; `lock_lost` <= 1; `rst_count` is not incremented again.
- `sw_rst_req` is ignored in WAIT_LOCK and SW_HOLD.
- Event priority: `rst` > lock loss > `sw_rst_req`. Simultaneous lock loss and sw request count as one event (lock loss path).
- `rst_count` saturates at all-ones; no wrap.
- `lock_lost_clr`=1 clears `lock_lost` on the next edge. If a lock-loss event occurs on the same edge, set wins.
- Resets never deassert out of order.
- Any return to reset asserts all three resets on the same edge.

Test Plan:
1. Defaults; `rst` high 5 cycles, then low with `pll_locked`=1 from the first post-reset cycle:
   - `rst_core` falls 16 cycles later, `rst_periph` 32 cycles after that, `rst_app` and `ready` 32 cycles after that.
   - `rst_count`=0.
2. `pll_locked` toggles low at cycle 10 of the filter, then stays high:
   - filter restarts; `rst_core` falls 16 cycles after the re-rise.
   - `lock_lost` stays 0.
3. In RUN, drop `pll_locked` for 1 cycle:
   - next edge all resets=1, `ready`=0, `lock_lost`=1, `rst_count`=1.
   - Full sequence repeats.
   - `lock_lost_clr` pulse then clears `lock_lost`.
4. In RUN, pulse `sw_rst_req`:
   - all resets=1 for 64 cycles, then WAIT_LOCK; `rst_core` falls 16 cycles later.
   - `rst_count`=1; `lock_lost`=0.
5. Assert `rst` mid-REL_PERIPH:
   - next edge all resets=1, `ready`=0, `rst_count`=0, `lock_lost`=0; sequence restarts from WAIT_LOCK.
6. Force 300 lock-loss events (CNT_W=8) → `rst_count` saturates at 255.
   - Same-edge `sw_rst_req` plus lock loss → counted once; state goes to WAIT_LOCK, not SW_HOLD.
